// File: rtl/ble_telemetry_tx.sv
// Telemetry transmitter for the BLE UART link: snapshots orientation and motor
// command into an 11-byte frame and shifts it out 8N1, LSB first, back-to-back.
module ble_telemetry_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       send_req,
  input  logic [9:0] roll,
  input  logic [9:0] pitch,
  input  logic [9:0] yaw,
  input  logic [9:0] motor_speed,
  input  logic       motor_dir,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] seq
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LastByte = 4'd10;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pending_q, pending_d;
  logic [7:0]  seq_q, seq_d;

  // Frame snapshot, frozen for the whole frame
  logic [7:0]  snap_seq_q, snap_seq_d;
  logic [9:0]  snap_roll_q, snap_roll_d;
  logic [9:0]  snap_pitch_q, snap_pitch_d;
  logic [9:0]  snap_yaw_q, snap_yaw_d;
  logic [9:0]  snap_speed_q, snap_speed_d;
  logic        snap_dir_q, snap_dir_d;

  logic [7:0]  roll_hi, pitch_hi, yaw_hi, motor_hi, checksum, next_byte;
  logic [3:0]  next_idx;
  logic        bit_end, start_frame;
  logic [7:0]  start_seq;

  // Payload bytes of the frame in flight; selects the byte following idx_q
  always_comb begin
    roll_hi  = {{6{snap_roll_q[9]}}, snap_roll_q[9:8]};
    pitch_hi = {{6{snap_pitch_q[9]}}, snap_pitch_q[9:8]};
    yaw_hi   = {{6{snap_yaw_q[9]}}, snap_yaw_q[9:8]};
    motor_hi = {snap_dir_q, 5'b0, snap_speed_q[9:8]};
    checksum = snap_seq_q + roll_hi + snap_roll_q[7:0] + pitch_hi + snap_pitch_q[7:0]
             + yaw_hi + snap_yaw_q[7:0] + motor_hi + snap_speed_q[7:0];
    next_idx = idx_q + 4'd1;
    case (next_idx)
      4'd1:    next_byte = snap_seq_q;
      4'd2:    next_byte = roll_hi;
      4'd3:    next_byte = snap_roll_q[7:0];
      4'd4:    next_byte = pitch_hi;
      4'd5:    next_byte = snap_pitch_q[7:0];
      4'd6:    next_byte = yaw_hi;
      4'd7:    next_byte = snap_yaw_q[7:0];
      4'd8:    next_byte = motor_hi;
      4'd9:    next_byte = snap_speed_q[7:0];
      default: next_byte = checksum;
    endcase
  end

  // Next-state logic for the serializer FSM, bit timer and request tracking
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pending_d    = pending_q;
    seq_d        = seq_q;
    snap_seq_d   = snap_seq_q;
    snap_roll_d  = snap_roll_q;
    snap_pitch_d = snap_pitch_q;
    snap_yaw_d   = snap_yaw_q;
    snap_speed_d = snap_speed_q;
    snap_dir_d   = snap_dir_q;
    start_frame  = 1'b0;
    start_seq    = seq_q;
    bit_end      = (cnt_q == BitLast);

    if (state_q != StIdle) begin
      cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    end

    case (state_q)
      StIdle: begin
        if (enable && send_req) start_frame = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q != LastByte) begin
            state_d = StStart;
            idx_d   = next_idx;
            shift_d = next_byte;
            tx_d    = 1'b0;
          end else begin
            done_d = 1'b1;
            seq_d  = seq_q + 8'd1;
            // A request on this very edge still chains the next frame
            if (enable && (pending_q || send_req)) begin
              start_frame = 1'b1;
              start_seq   = seq_q + 8'd1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      state_d      = StStart;
      cnt_d        = 16'd0;
      idx_d        = 4'd0;
      shift_d      = SYNC_BYTE;
      tx_d         = 1'b0;
      busy_d       = 1'b1;
      pending_d    = 1'b0;
      snap_seq_d   = start_seq;
      snap_roll_d  = roll;
      snap_pitch_d = pitch;
      snap_yaw_d   = yaw;
      snap_speed_d = motor_speed;
      snap_dir_d   = motor_dir;
    end else if (!enable) begin
      pending_d = 1'b0;
    end else if (send_req && state_q != StIdle) begin
      pending_d = 1'b1;
    end
  end

  // State registers; reset aborts any frame and forces the line idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      bit_q        <= 3'd0;
      idx_q        <= 4'd0;
      shift_q      <= 8'd0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pending_q    <= 1'b0;
      seq_q        <= 8'd0;
      snap_seq_q   <= 8'd0;
      snap_roll_q  <= 10'd0;
      snap_pitch_q <= 10'd0;
      snap_yaw_q   <= 10'd0;
      snap_speed_q <= 10'd0;
      snap_dir_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pending_q    <= pending_d;
      seq_q        <= seq_d;
      snap_seq_q   <= snap_seq_d;
      snap_roll_q  <= snap_roll_d;
      snap_pitch_q <= snap_pitch_d;
      snap_yaw_q   <= snap_yaw_d;
      snap_speed_q <= snap_speed_d;
      snap_dir_q   <= snap_dir_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign seq        = seq_q;

endmodule
